// File: rtl/systolic_feeder.sv
// Operand sequencer for a SIZE x SIZE systolic MAC array: holds one A and one W
// tile, then clears the array and streams diagonally skewed operands into it.
module systolic_feeder #(
    parameter int SIZE        = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAC_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [$clog2(SIZE)-1:0]      wr_row,
    input  logic [$clog2(SIZE)-1:0]      wr_col,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         start,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic                         acc_clear,
    output logic                         enable,
    output logic [SIZE*DATA_WIDTH-1:0]   a_bus,
    output logic [SIZE*DATA_WIDTH-1:0]   w_bus
);
    localparam int IW     = $clog2(SIZE);
    localparam int TW     = $clog2(3 * SIZE);
    localparam int LW     = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam int T_LAST = 3 * SIZE - 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [TW-1:0]       t_reg, t_next;
    logic [LW-1:0]       d_reg, d_next;
    logic [DATA_WIDTH-1:0] a_tile [SIZE][SIZE];
    logic [DATA_WIDTH-1:0] w_tile [SIZE][SIZE];
    logic [SIZE*DATA_WIDTH-1:0] a_bus_reg, a_bus_next;
    logic [SIZE*DATA_WIDTH-1:0] w_bus_reg, w_bus_next;
    logic                stream_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            t_reg     <= '0;
            d_reg     <= '0;
            a_bus_reg <= '0;
            w_bus_reg <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            d_reg     <= d_next;
            a_bus_reg <= a_bus_next;
            w_bus_reg <= w_bus_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        d_next     = d_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                state_next = S_STREAM;
                t_next     = '0;
            end
            S_STREAM: begin
                if (t_reg == TW'(T_LAST)) begin
                    state_next = S_DRAIN;
                    t_next     = '0;
                    d_next     = '0;
                end else begin
                    t_next = t_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                if (d_reg == LW'(MAC_LATENCY - 1)) state_next = S_DONE;
                else                                d_next     = d_reg + 1'b1;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Tiles only change in IDLE, so the operand buses can be computed one
    // cycle ahead from the next-state values and registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    a_tile[r][c] <= '0;
                    w_tile[r][c] <= '0;
                end
            end
        end else if (wr_en && state_reg == S_IDLE) begin
            if (wr_sel) w_tile[wr_row][wr_col] <= wr_data;
            else        a_tile[wr_row][wr_col] <= wr_data;
        end
    end

    assign stream_next = (state_next == S_STREAM);

    // Row r and column c share the same skew: element index k = t - gi.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        logic [TW-1:0] k_idx;
        logic          hit;
        assign k_idx = t_next - TW'(gi);
        assign hit   = stream_next && (t_next >= TW'(gi)) && (k_idx < TW'(SIZE));
        assign a_bus_next[gi*DATA_WIDTH +: DATA_WIDTH] =
            hit ? a_tile[gi][k_idx[IW-1:0]] : '0;
        assign w_bus_next[gi*DATA_WIDTH +: DATA_WIDTH] =
            hit ? w_tile[k_idx[IW-1:0]][gi] : '0;
    end

    assign ready     = (state_reg == S_IDLE);
    assign busy      = (state_reg == S_CLEAR) || (state_reg == S_STREAM) || (state_reg == S_DRAIN);
    assign done      = (state_reg == S_DONE);
    assign acc_clear = (state_reg == S_CLEAR);
    assign enable    = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
    assign a_bus     = a_bus_reg;
    assign w_bus     = w_bus_reg;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a behavioural 4x4 MAC array is driven
// by the DUT outputs and its accumulators are compared with a reference matmul.
module tb_systolic_feeder;
    localparam int SIZE = 4;
    localparam int DW   = 8;
    localparam int ML   = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic                 wr_sel = 1'b0;
    logic [1:0]           wr_row = '0;
    logic [1:0]           wr_col = '0;
    logic [DW-1:0]        wr_data = '0;
    logic                 start = 1'b0;
    logic                 ready, busy, done, acc_clear, enable;
    logic [SIZE*DW-1:0]   a_bus, w_bus;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .MAC_LATENCY(ML)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .ready(ready),
        .busy(busy), .done(done), .acc_clear(acc_clear), .enable(enable),
        .a_bus(a_bus), .w_bus(w_bus)
    );

    always #5 clk = ~clk;

    // Behavioural array: a forwards right, w forwards down, one cycle per hop.
    int                  acc [SIZE][SIZE];
    logic signed [DW-1:0] ap [SIZE][SIZE];
    logic signed [DW-1:0] wp [SIZE][SIZE];
    logic signed [DW-1:0] ai, wi;

    always @(posedge clk) begin
        if (rst || acc_clear) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++) begin
                    acc[r][c] <= 0;
                    ap[r][c]  <= '0;
                    wp[r][c]  <= '0;
                end
        end else if (enable) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++) begin
                    if (c == 0) ai = $signed(a_bus[r*DW +: DW]);
                    else        ai = ap[r][c-1];
                    if (r == 0) wi = $signed(w_bus[c*DW +: DW]);
                    else        wi = wp[r-1][c];
                    acc[r][c] <= acc[r][c] + int'(ai) * int'(wi);
                    ap[r][c]  <= ai;
                    wp[r][c]  <= wi;
                end
        end
    end

    // Bench copy of the tiles, as signed integers.
    int ma [SIZE][SIZE];
    int mw [SIZE][SIZE];

    typedef struct {
        int         t;
        logic [7:0] a_row2;
        logic [7:0] w_col3;
    } skew_vec_t;
    skew_vec_t skew_tab [10];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_elem(input logic sel, input int row, input int col, input int val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(row);
        wr_col  = 2'(col);
        wr_data = DW'(val);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) mw[row][col] = val;
        else     ma[row][col] = val;
    endtask

    function automatic int a_val(input int mode, input int r, input int k);
        case (mode)
            1:       return (r == k) ? 1 : 0;
            2:       return 16 * r + k + 1;
            3:       return -128;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int w_val(input int mode, input int k, input int c);
        case (mode)
            1:       return 4 * k + c + 1;
            3:       return -128;
            5:       return -1;
            default: return 0;
        endcase
    endfunction

    task automatic load_tiles(input int amode, input int wmode);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                write_elem(1'b0, r, c, a_val(amode, r, c));
                write_elem(1'b1, r, c, w_val(wmode, r, c));
            end
    endtask

    task automatic check_pes(input string tag);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                int exp_v = 0;
                for (int k = 0; k < SIZE; k++) exp_v += ma[r][k] * mw[k][c];
                check($sformatf("%s PE(%0d,%0d)", tag, r, c), acc[r][c], exp_v);
            end
    endtask

    // One multiply, observed for a fixed window. Optionally checks skew vectors
    // and injects a start + A[0][0]=99 write while busy at inject_cyc.
    task automatic run_mult(input string tag, input bit do_skew, input int inject_cyc);
        int lat = 0, ndone = 0, nen = 0, nclr = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                ndone++;
                if (lat == 0) lat = cyc;
            end
            if (enable)    nen++;
            if (acc_clear) nclr++;
            if (do_skew && cyc >= 2 && cyc <= 11) begin
                check($sformatf("%s a_bus row2 t=%0d", tag, skew_tab[cyc-2].t),
                      a_bus[2*DW +: DW], skew_tab[cyc-2].a_row2);
                check($sformatf("%s w_bus col3 t=%0d", tag, skew_tab[cyc-2].t),
                      w_bus[3*DW +: DW], skew_tab[cyc-2].w_col3);
            end
            if (cyc == inject_cyc) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
                wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd99;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        $display("[TB] run %s: done at cycle %0d, %0d done pulse(s), enable %0d cycles",
                 tag, lat, ndone, nen);
        check({tag, " done latency"}, lat, 3 * SIZE + ML);
        check({tag, " done pulses"}, ndone, 1);
        check({tag, " enable cycles"}, nen, 3 * SIZE - 2 + ML);
        check({tag, " acc_clear cycles"}, nclr, 1);
        check_pes(tag);
    endtask

    initial begin
        int cnt;
        skew_tab[0] = '{0, 8'd0,  8'd0};
        skew_tab[1] = '{1, 8'd0,  8'd0};
        skew_tab[2] = '{2, 8'd33, 8'd0};
        skew_tab[3] = '{3, 8'd34, 8'd4};
        skew_tab[4] = '{4, 8'd35, 8'd8};
        skew_tab[5] = '{5, 8'd36, 8'd12};
        skew_tab[6] = '{6, 8'd0,  8'd16};
        skew_tab[7] = '{7, 8'd0,  8'd0};
        skew_tab[8] = '{8, 8'd0,  8'd0};
        skew_tab[9] = '{9, 8'd0,  8'd0};
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                ma[r][c] = 0;
                mw[r][c] = 0;
            end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset acc_clear", acc_clear, 0);
        check("reset enable", enable, 0);
        check("reset a_bus", a_bus, 0);
        check("reset w_bus", w_bus, 0);

        // Identity
        load_tiles(1, 1);
        run_mult("identity", 1'b0, 0);
        check("identity PE(3,2) hand", acc[3][2], 15);

        // Skew
        load_tiles(2, 1);
        run_mult("skew", 1'b1, 0);

        // Signed extremes
        load_tiles(3, 3);
        run_mult("neg128", 1'b0, 0);
        check("neg128 PE(1,1) hand", acc[1][1], 65536);
        load_tiles(4, 5);
        run_mult("ones_x_neg1", 1'b0, 0);
        check("ones_x_neg1 PE(2,3) hand", acc[2][3], -4);

        // Reset in the middle of STREAM (t=5 is cycle 7 after the start edge)
        load_tiles(2, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre-reset enable", enable, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst ready", ready, 1);
        check("midrst busy", busy, 0);
        check("midrst enable", enable, 0);
        check("midrst a_bus", a_bus, 0);
        check("midrst w_bus", w_bus, 0);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                ma[r][c] = 0;
                mw[r][c] = 0;
            end
        run_mult("after_reset", 1'b0, 0);

        // Busy rejection: start and a write during STREAM are ignored
        load_tiles(1, 1);
        run_mult("busy_inject", 1'b0, 5);
        run_mult("rerun", 1'b0, 0);

        // Back-to-back: start in DONE ignored, start in following IDLE runs
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 40) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check("b2b first done", done, 1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b start in done ignored ready", ready, 1);
        check("b2b start in done ignored busy", busy, 0);
        wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd7;
        mw[0][0] = 7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check("b2b acc_clear", acc_clear, 1);
        cnt = 1;
        while (!done && cnt < 40) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        $display("[TB] run b2b: done at cycle %0d", cnt);
        check("b2b second latency", cnt, 3 * SIZE + ML);
        check_pes("b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
